ps2_kbd_ctrl: RTL and testbench
===============================

PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the make-event counter press_cnt.
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port kbd_data, input, 8: head-of-FIFO scan code from the PS/2 receiver.
REQ-005 SHALL have port kbd_ready, input, 1: receiver FIFO non-empty.
REQ-006 SHALL have port kbd_overflow, input, 1: receiver FIFO overflow flag.
REQ-007 SHALL have port kbd_nextdata_n, output, 1: active-low pop strobe to the receiver; registered.
REQ-008 SHALL have port evt_valid, output, 1: key event available.
REQ-009 SHALL have port evt_ready, input, 1: consumer accepts the event.
REQ-010 SHALL have port evt_code, output, 8: final scan-code byte of the event.
REQ-011 SHALL have port evt_ext, output, 1: event was prefixed by 0xE0.
REQ-012 SHALL have port evt_release, output, 1: event was prefixed by 0xF0 (break).
REQ-013 SHALL have port key_held, output, 1: last made key is still down.
REQ-014 SHALL have port press_cnt, output, CNT_W: count of accepted make events.
REQ-015 SHALL have port ovf_err, output, 1: sticky receiver-overflow flag.

Function
REQ-016 SHALL implement FSM states IDLE, POP, SETTLE, DECODE, EMIT.
REQ-017 IDLE: if kbd_ready=1, capture kbd_data into byte register and go to POP; otherwise stay in IDLE.
REQ-018 POP: kbd_nextdata_n=0 for exactly this one cycle; next state SETTLE. kbd_nextdata_n=1 in all other states.
REQ-019 SETTLE: one-cycle wait so that the receiver's ready/pointer update is visible; next state DECODE.
REQ-020 DECODE, byte 0xF0: set brk flag, go to IDLE.
REQ-021 DECODE, byte 0xE0: set ext flag, go to IDLE.
REQ-022 DECODE, any other byte: load evt_code=byte, evt_ext=ext, evt_release=brk, go to EMIT.
REQ-023 Prefix flags accumulate in any order: repeated F0 keeps brk=1; E0 after F0 keeps brk.
REQ-024 EMIT: evt_valid=1 and evt_* held stable until evt_ready=1.
  - On the cycle with evt_ready=1: clear brk/ext, update key state, go to IDLE.
  - evt_valid=0 in every other state.
REQ-025 No pop SHALL occur while in EMIT, regardless of kbd_ready (backpressure to the receiver FIFO).
REQ-026 On make accept: store {ext,code} as last_make, set key_held=1, press_cnt+1 (wraps from all-ones to 0).
REQ-027 On break accept: clear key_held only if {ext,code} equals last_make; press_cnt unchanged.
REQ-028 Throughput: a prefix byte costs 4 cycles (IDLE..DECODE); a code byte costs 5 cycles plus EMIT stall.
REQ-029 ovf_err SHALL set on any cycle with kbd_overflow=1 and clear only on rst.
REQ-030 Bytes 0x00, 0xAA and 0xFA SHALL be treated as ordinary codes.

Reset
REQ-031 rst=1 SHALL immediately force, regardless of clk:
  - state IDLE, kbd_nextdata_n=1, evt_valid=0;
  - evt_code=0, evt_ext=0, evt_release=0;
  - key_held=0, press_cnt=0, ovf_err=0;
  - brk/ext flags=0, last_make=0.
REQ-032 Reset mid-operation SHALL discard any captured or popped byte and any pending event; after rst deasserts, the next byte is processed normally.

Configuration
REQ-033 Macro PS2_KBD_CTRL_REPEAT_FILTER_EN defined: in DECODE, a make (brk=0) whose {ext,code} equals last_make while key_held=1 is dropped. The block clears the flags, goes to IDLE, does not enter EMIT and does not count it.
REQ-034 Macro undefined: typematic repeats are emitted and counted like any make event.

Verification
REQ-035 Stream 0x1C, evt_ready=1 -> one kbd_nextdata_n low pulse; one evt_valid cycle with code=0x1C, ext=0, release=0; press_cnt=1; key_held=1.
REQ-036 Stream 1C F0 1C -> second event has code=0x1C, release=1; key_held=0; press_cnt=1; three pop pulses total.
REQ-037 Stream E0 F0 75 -> single event with code=0x75, ext=1, release=1; three pops; flags cleared afterwards.
REQ-038 Event pending with evt_ready=0 for 10 cycles, kbd_ready=1 -> evt_valid and evt_* stable, no pop pulse; evt_ready=1 -> accepted in 1 cycle, then the pop resumes.
REQ-039 Stream 1C 1C 1C -> macro defined: one event, press_cnt=1; macro undefined: three events, press_cnt=3.
REQ-040 One-cycle kbd_overflow pulse -> ovf_err=1 and held; rst pulse during SETTLE -> all outputs at reset values, next byte 0x24 yields an event with code=0x24.

Source files
------------

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard scan-code decoder: pops bytes from a receiver FIFO, folds E0/F0 prefixes
// into key events with valid/ready handshake. Define PS2_KBD_CTRL_REPEAT_FILTER_EN to drop typematic repeats.
module ps2_kbd_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  input  logic             kbd_overflow,
  output logic             kbd_nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_release,
  output logic             key_held,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_err
);

  typedef enum logic [2:0] {IDLE, POP, SETTLE, DECODE, EMIT} state_e;

  state_e             state_q, state_d;
  logic [7:0]         data_q, data_d;
  logic               brk_q, brk_d;
  logic               ext_q, ext_d;
  logic [7:0]         code_q, code_d;
  logic               evt_ext_q, evt_ext_d;
  logic               evt_rel_q, evt_rel_d;
  logic [8:0]         last_make_q, last_make_d;
  logic               held_q, held_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               nextdata_n_q, nextdata_n_d;
  logic               drop_repeat;

`ifdef PS2_KBD_CTRL_REPEAT_FILTER_EN
  assign drop_repeat = !brk_q && held_q && ({ext_q, data_q} == last_make_q);
`else
  assign drop_repeat = 1'b0;
`endif

  // NOTE: every _d gets a default before the case so no path leaves a latch behind.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    brk_d       = brk_q;
    ext_d       = ext_q;
    code_d      = code_q;
    evt_ext_d   = evt_ext_q;
    evt_rel_d   = evt_rel_q;
    last_make_d = last_make_q;
    held_d      = held_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q | kbd_overflow;
    case (state_q)
      IDLE: begin
        if (kbd_ready) begin
          data_d  = kbd_data;
          state_d = POP;
        end
      end
      POP:    state_d = SETTLE;
      SETTLE: state_d = DECODE;
      DECODE: begin
        state_d = IDLE;
        if (data_q == 8'hF0) begin
          brk_d = 1'b1;
        end else if (data_q == 8'hE0) begin
          ext_d = 1'b1;
        end else if (drop_repeat) begin
          brk_d = 1'b0;
          ext_d = 1'b0;
        end else begin
          code_d    = data_q;
          evt_ext_d = ext_q;
          evt_rel_d = brk_q;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        // Stall here without popping so the receiver FIFO absorbs backpressure.
        if (evt_ready) begin
          brk_d   = 1'b0;
          ext_d   = 1'b0;
          state_d = IDLE;
          if (evt_rel_q) begin
            if ({evt_ext_q, code_q} == last_make_q) held_d = 1'b0;
          end else begin
            last_make_d = {evt_ext_q, code_q};
            held_d      = 1'b1;
            cnt_d       = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Strobe is registered: low exactly while the state register holds POP.
    nextdata_n_d = (state_d != POP);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      data_q       <= 8'h00;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      code_q       <= 8'h00;
      evt_ext_q    <= 1'b0;
      evt_rel_q    <= 1'b0;
      last_make_q  <= 9'h000;
      held_q       <= 1'b0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      nextdata_n_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      code_q       <= code_d;
      evt_ext_q    <= evt_ext_d;
      evt_rel_q    <= evt_rel_d;
      last_make_q  <= last_make_d;
      held_q       <= held_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      nextdata_n_q <= nextdata_n_d;
    end
  end

  assign kbd_nextdata_n = nextdata_n_q;
  assign evt_valid      = (state_q == EMIT);
  assign evt_code       = code_q;
  assign evt_ext        = evt_ext_q;
  assign evt_release    = evt_rel_q;
  assign key_held       = held_q;
  assign press_cnt      = cnt_q;
  assign ovf_err        = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: a receiver FIFO model feeds bytes, expected events are
// queued as bytes are pushed and compared as the DUT hands events over.
module tb_ps2_kbd_ctrl;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_overflow;
  logic       kbd_nextdata_n;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_release;
  logic       key_held;
  logic [7:0] press_cnt;
  logic       ovf_err;

  ps2_kbd_ctrl #(.CNT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .kbd_data       (kbd_data),
    .kbd_ready      (kbd_ready),
    .kbd_overflow   (kbd_overflow),
    .kbd_nextdata_n (kbd_nextdata_n),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_code       (evt_code),
    .evt_ext        (evt_ext),
    .evt_release    (evt_release),
    .key_held       (key_held),
    .press_cnt      (press_cnt),
    .ovf_err        (ovf_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Receiver FIFO model: written by tasks, read pointer owned by the negedge process.
  logic [7:0] rx_mem [0:2047];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         pops = 0;
  int         valid_cycles = 0;
  evt_t       obs_mem [0:2047];
  int         obs_wr = 0;
  int         obs_rd = 0;
  evt_t       exp_q[$];
  logic [7:0] exp_cnt = 8'h00;

  always @(negedge clk) begin
    int rp;
    rp = rd_ptr;
    if (!kbd_nextdata_n && rp != wr_ptr) begin
      rp = rp + 1;
      pops <= pops + 1;
    end
    rd_ptr <= rp;
    if (evt_valid) valid_cycles <= valid_cycles + 1;
    if (evt_valid && evt_ready) begin
      obs_mem[obs_wr] <= {evt_code, evt_ext, evt_release};
      obs_wr <= obs_wr + 1;
    end
    kbd_ready <= (rp != wr_ptr);
    kbd_data  <= (rp != wr_ptr) ? rx_mem[rp] : 8'h00;
  end

  task automatic push_byte(input logic [7:0] b);
    rx_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic expect_evt(input logic [7:0] code, input logic ext, input logic rel);
    evt_t e;
    e = {code, ext, rel};
    exp_q.push_back(e);
    if (!rel) exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic compare_obs(input string name);
    evt_t o;
    evt_t e;
    while (obs_rd != obs_wr) begin
      o = obs_mem[obs_rd];
      obs_rd = obs_rd + 1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected event got code=%h ext=%b rel=%b", name, o.code, o.ext, o.rel);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL %s event got code=%h ext=%b rel=%b exp code=%h ext=%b rel=%b",
                   name, o.code, o.ext, o.rel, e.code, e.ext, e.rel);
        end
      end
    end
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 4000;
    while ((exp_q.size() != 0 || rd_ptr != wr_ptr || obs_rd != obs_wr) && budget > 0) begin
      @(posedge clk); #1;
      compare_obs(name);
      budget--;
    end
    repeat (8) @(posedge clk);
    #1;
    compare_obs(name);
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL %s timeout, %0d events still expected", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; kbd_overflow = 1'b0; evt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({kbd_nextdata_n, evt_valid, evt_code, evt_ext, evt_release, key_held, press_cnt, ovf_err}
        !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got n=%b v=%b code=%h ext=%b rel=%b held=%b cnt=%h ovf=%b",
               kbd_nextdata_n, evt_valid, evt_code, evt_ext, evt_release, key_held, press_cnt, ovf_err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_make();
    int v0;
    v0 = valid_cycles;
    push_byte(8'h1C); expect_evt(8'h1C, 1'b0, 1'b0);
    drain("single_make");
    checks++;
    if ({pops, valid_cycles - v0, press_cnt, key_held} !== {32'd1, 32'd1, 8'd1, 1'b1}) begin
      errors++;
      $display("FAIL single_make pops=%0d valid_cycles=%0d cnt=%0d held=%b exp 1 1 1 1",
               pops, valid_cycles - v0, press_cnt, key_held);
    end
  endtask

  task automatic test_break();
    push_byte(8'hF0); push_byte(8'h1C); expect_evt(8'h1C, 1'b0, 1'b1);
    drain("break");
    checks++;
    if ({pops, press_cnt, key_held} !== {32'd3, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL break pops=%0d cnt=%0d held=%b exp 3 1 0", pops, press_cnt, key_held);
    end
  endtask

  task automatic test_ext_prefix();
    int p0;
    push_byte(8'hE0); push_byte(8'h75); expect_evt(8'h75, 1'b1, 1'b0);
    push_byte(8'hF0); push_byte(8'h75); expect_evt(8'h75, 1'b0, 1'b1);
    drain("ext_make_plain_break");
    checks++;
    if (key_held !== 1'b1) begin
      errors++;
      $display("FAIL ext_other_key_break held=%b exp 1", key_held);
    end
    p0 = pops;
    push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75); expect_evt(8'h75, 1'b1, 1'b1);
    drain("ext_break");
    checks++;
    if ({pops - p0, key_held} !== {32'd3, 1'b0}) begin
      errors++;
      $display("FAIL ext_break pops=%0d held=%b exp 3 0", pops - p0, key_held);
    end
    push_byte(8'hF0); push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h11);
    expect_evt(8'h11, 1'b1, 1'b1);
    push_byte(8'h11); expect_evt(8'h11, 1'b0, 1'b0);
    drain("prefix_order");
    checks++;
    if (press_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL prefix_order cnt got %0d exp %0d", press_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    int budget;
    evt_ready = 1'b0;
    push_byte(8'h2A); expect_evt(8'h2A, 1'b0, 1'b0);
    push_byte(8'h3B); expect_evt(8'h3B, 1'b0, 1'b0);
    budget = 50;
    while (!evt_valid && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL backpressure no evt_valid within 50 cycles");
    end
    p0 = pops;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({evt_valid, evt_code, evt_ext, evt_release, kbd_nextdata_n, pops - p0, kbd_ready}
          !== {1'b1, 8'h2A, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1}) begin
        errors++;
        $display("FAIL backpressure cycle %0d v=%b code=%h ext=%b rel=%b n=%b pops=%0d rdy=%b",
                 i, evt_valid, evt_code, evt_ext, evt_release, kbd_nextdata_n, pops - p0, kbd_ready);
      end
    end
    evt_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL accept_latency evt_valid got %b exp 0", evt_valid);
    end
    drain("back_to_back");
    checks++;
    if ({pops - p0, press_cnt} !== {32'd1, exp_cnt}) begin
      errors++;
      $display("FAIL pop_resume pops=%0d cnt=%0d exp 1 %0d", pops - p0, press_cnt, exp_cnt);
    end
  endtask

  task automatic test_repeat();
    int p0;
    p0 = pops;
    push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h1C);
    expect_evt(8'h1C, 1'b0, 1'b0);
`ifndef PS2_KBD_CTRL_REPEAT_FILTER_EN
    expect_evt(8'h1C, 1'b0, 1'b0);
    expect_evt(8'h1C, 1'b0, 1'b0);
`endif
    drain("repeat");
    checks++;
    if ({pops - p0, press_cnt, key_held} !== {32'd3, exp_cnt, 1'b1}) begin
      errors++;
      $display("FAIL repeat pops=%0d cnt=%0d held=%b exp 3 %0d 1", pops - p0, press_cnt, key_held, exp_cnt);
    end
  endtask

  task automatic test_special_codes();
    push_byte(8'h00); expect_evt(8'h00, 1'b0, 1'b0);
    push_byte(8'hAA); expect_evt(8'hAA, 1'b0, 1'b0);
    push_byte(8'hFA); expect_evt(8'hFA, 1'b0, 1'b0);
    push_byte(8'hF0); push_byte(8'h00); expect_evt(8'h00, 1'b0, 1'b1);
    drain("special_codes");
    checks++;
    if ({key_held, press_cnt} !== {1'b1, exp_cnt}) begin
      errors++;
      $display("FAIL stale_break held=%b cnt=%0d exp 1 %0d", key_held, press_cnt, exp_cnt);
    end
    push_byte(8'hF0); push_byte(8'hFA); expect_evt(8'hFA, 1'b0, 1'b1);
    drain("last_break");
    checks++;
    if (key_held !== 1'b0) begin
      errors++;
      $display("FAIL last_break held=%b exp 0", key_held);
    end
  endtask

  task automatic test_overflow();
    kbd_overflow = 1'b1;
    @(posedge clk); #1;
    kbd_overflow = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ovf_err !== 1'b1) begin
        errors++;
        $display("FAIL ovf_sticky cycle %0d ovf_err=%b exp 1", i, ovf_err);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    int lows;
    int budget;
    push_byte(8'hF0); push_byte(8'h55);
    lows = 0;
    budget = 100;
    while (lows < 2 && budget > 0) begin
      @(posedge clk); #1;
      if (!kbd_nextdata_n) lows++;
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL reset_mid pop pulses got %0d exp 2", lows);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({kbd_nextdata_n, evt_valid, evt_code, evt_ext, evt_release, key_held, press_cnt, ovf_err}
        !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got n=%b v=%b code=%h ext=%b rel=%b held=%b cnt=%h ovf=%b",
               kbd_nextdata_n, evt_valid, evt_code, evt_ext, evt_release, key_held, press_cnt, ovf_err);
    end
    exp_cnt = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    push_byte(8'h24); expect_evt(8'h24, 1'b0, 1'b0);
    drain("after_reset");
    checks++;
    if ({press_cnt, key_held, ovf_err} !== {8'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL after_reset cnt=%0d held=%b ovf=%b exp 1 1 0", press_cnt, key_held, ovf_err);
    end
  endtask

  task automatic test_cnt_wrap();
    int n;
    logic [7:0] code;
    n = 256 - int'(exp_cnt);
    for (int i = 0; i < n; i++) begin
      code = (i % 2 == 0) ? 8'h10 : 8'h11;
      push_byte(code);
      expect_evt(code, 1'b0, 1'b0);
    end
    drain("cnt_wrap");
    checks++;
    if ({press_cnt, exp_cnt} !== {8'h00, 8'h00}) begin
      errors++;
      $display("FAIL cnt_wrap cnt got %0d exp 0", press_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_break();
    test_ext_prefix();
    test_back_to_back();
    test_repeat();
    test_special_codes();
    test_overflow();
    test_reset_mid();
    test_cnt_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
